// File: rtl/delay_line_var.sv
// delay_line_var: data + valid delay line whose delay (1..MAX_DLT enabled cycles) is loaded at run time,
// with stall (en), flush and clamped delay load. Define DELAY_LINE_OCC_EN to add the occ occupancy output.
module delay_line_var #(
   parameter  int DW       = 8,
   parameter  int MAX_DLT  = 16,
   parameter  int DLT_INIT = 1,
   localparam int DLW      = $clog2(MAX_DLT + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic [DW-1:0]  xi,
   input  logic           vi,
   output logic [DW-1:0]  xo,
   output logic           vo,
   input  logic [DLW-1:0] dly_i,
   input  logic           dly_ld,
   input  logic           flush,
   output logic [DLW-1:0] dly_o,
   output logic           dly_err
`ifdef DELAY_LINE_OCC_EN
   ,
   output logic [DLW-1:0] occ
`endif
);

   function automatic logic [DLW-1:0] clamp_dly(input logic [DLW-1:0] req);
      logic [DLW-1:0] res;
      if (req == {DLW{1'b0}}) begin
         res = DLW'(1);
      end else if (req > DLW'(MAX_DLT)) begin
         res = DLW'(MAX_DLT);
      end else begin
         res = req;
      end
      return res;
   endfunction

   logic [DW-1:0]      d_r [MAX_DLT];
   logic [MAX_DLT-1:0] v_r;
   logic [DLW-1:0]     dly_r;
   logic               err_r;
   logic [DLW-1:0]     tap_s;
   logic [DLW-1:0]     dly_clamp_s;
   logic               clr_s;
   logic               shift_s;

   assign clr_s       = dly_ld | flush;
   assign shift_s     = en & ~clr_s;
   assign tap_s       = dly_r - DLW'(1);
   assign dly_clamp_s = clamp_dly(dly_i);
   assign dly_o       = dly_r;
   assign dly_err     = err_r;

   // Output tap: selects stage dly_o-1, driven from flops only.
   always_comb begin
      xo = {DW{1'b0}};
      vo = 1'b0;
      for (int k = 0; k < MAX_DLT; k++) begin
         xo = (tap_s == DLW'(k)) ? d_r[k] : xo;
         vo = (tap_s == DLW'(k)) ? v_r[k] : vo;
      end
   end

   // Data stages: shift on enabled edges; flush/load leaves the data untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < MAX_DLT; k++) begin
            d_r[k] <= {DW{1'b0}};
         end
      end else if (shift_s) begin
         d_r[0] <= xi;
         for (int k = 1; k < MAX_DLT; k++) begin
            d_r[k] <= d_r[k-1];
         end
      end
   end

   // Valid stages: cleared by flush/load even while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_r <= {MAX_DLT{1'b0}};
      end else if (clr_s) begin
         v_r <= {MAX_DLT{1'b0}};
      end else if (shift_s) begin
         v_r[0] <= vi;
         for (int k = 1; k < MAX_DLT; k++) begin
            v_r[k] <= v_r[k-1];
         end
      end
   end

   // Delay register and clamp-error pulse; the error bit is rewritten on every edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly_r <= DLW'(DLT_INIT);
         err_r <= 1'b0;
      end else begin
         err_r <= dly_ld & (dly_clamp_s != dly_i);
         if (dly_ld) begin
            dly_r <= dly_clamp_s;
         end
      end
   end

`ifdef DELAY_LINE_OCC_EN
   logic [DLW-1:0] occ_r;

   assign occ = occ_r;

   // Occupancy of the active window: one entry enters with vi, one leaves with vo.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_r <= {DLW{1'b0}};
      end else if (clr_s) begin
         occ_r <= {DLW{1'b0}};
      end else if (en) begin
         occ_r <= occ_r + DLW'(vi) - DLW'(vo);
      end
   end
`endif

endmodule

// File: tb/tb_delay_line_var.sv
// Self-checking bench for delay_line_var: directed scenarios plus randomized traffic checked
// against a queue-based history model of the delay line.
`timescale 1ns/1ps
module tb_delay_line_var;
   localparam int DW       = 8;
   localparam int MAX_DLT  = 16;
   localparam int DLT_INIT = 1;
   localparam int DLW      = $clog2(MAX_DLT + 1);

   logic           clk    = 1'b0;
   logic           rst_n  = 1'b0;
   logic           en     = 1'b0;
   logic           vi     = 1'b0;
   logic           dly_ld = 1'b0;
   logic           flush  = 1'b0;
   logic [DW-1:0]  xi     = '0;
   logic [DLW-1:0] dly_i  = '0;
   logic [DW-1:0]  xo;
   logic           vo;
   logic [DLW-1:0] dly_o;
   logic           dly_err;
`ifdef DELAY_LINE_OCC_EN
   logic [DLW-1:0] occ;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Model: full history of accepted words; flush/load invalidates everything in flight.
   logic [DW-1:0] m_d[$];
   logic          m_v[$];
   int            m_dly;
   logic          m_err;

   always #5 clk = ~clk;

   delay_line_var #(.DW(DW), .MAX_DLT(MAX_DLT), .DLT_INIT(DLT_INIT)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .xi(xi), .vi(vi), .xo(xo), .vo(vo),
      .dly_i(dly_i), .dly_ld(dly_ld), .flush(flush), .dly_o(dly_o), .dly_err(dly_err)
`ifdef DELAY_LINE_OCC_EN
      , .occ(occ)
`endif
   );

   function automatic int clamp_ref(input int r);
      if (r < 1) return 1;
      if (r > MAX_DLT) return MAX_DLT;
      return r;
   endfunction

   task automatic model_reset();
      m_d.delete();
      m_v.delete();
      for (int i = 0; i < MAX_DLT; i++) begin
         m_d.push_back('0);
         m_v.push_back(1'b0);
      end
      m_dly = DLT_INIT;
      m_err = 1'b0;
   endtask

   task automatic model_edge(input logic e, input logic [DW-1:0] x, input logic v,
                             input logic f, input logic l, input logic [DLW-1:0] di);
      m_err = l && (clamp_ref(int'(di)) != int'(di));
      if (l || f) begin
         foreach (m_v[i]) m_v[i] = 1'b0;
         if (l) m_dly = clamp_ref(int'(di));
      end else if (e) begin
         m_d.push_back(x);
         m_v.push_back(v);
         void'(m_d.pop_front());
         void'(m_v.pop_front());
      end
   endtask

   function automatic logic [DW-1:0] exp_xo();
      return m_d[MAX_DLT - m_dly];
   endfunction

   function automatic logic exp_vo();
      return m_v[MAX_DLT - m_dly];
   endfunction

   function automatic logic [DLW-1:0] exp_occ();
      int s = 0;
      for (int i = MAX_DLT - m_dly; i < MAX_DLT; i++) s += int'(m_v[i]);
      return DLW'(s);
   endfunction

   // Applies one cycle of inputs, updates the model at the edge, returns at the next falling edge.
   task automatic drive(input logic e, input logic [DW-1:0] x, input logic v,
                        input logic f, input logic l, input logic [DLW-1:0] di);
      en = e; xi = x; vi = v; flush = f; dly_ld = l; dly_i = di;
      @(posedge clk);
      model_edge(e, x, v, f, l, di);
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_checks++; if (xo !== 8'h00) begin n_fail++; $display("FAIL reset_xo got %h exp 00", xo); end
      n_checks++; if (vo !== 1'b0) begin n_fail++; $display("FAIL reset_vo got %b exp 0", vo); end
      n_checks++; if (dly_o !== DLW'(DLT_INIT)) begin n_fail++; $display("FAIL reset_dly_o got %0d exp %0d", dly_o, DLT_INIT); end
      n_checks++; if (dly_err !== 1'b0) begin n_fail++; $display("FAIL reset_dly_err got %b exp 0", dly_err); end
`ifdef DELAY_LINE_OCC_EN
      n_checks++; if (occ !== 5'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", occ); end
`endif
      drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 5'd0);
      n_checks++; if (xo !== 8'h11 || vo !== 1'b1) begin n_fail++; $display("FAIL d1_first got %h/%b exp 11/1", xo, vo); end
      drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 5'd0);
      n_checks++; if (xo !== 8'h22 || vo !== 1'b1) begin n_fail++; $display("FAIL d1_second got %h/%b exp 22/1", xo, vo); end
      n_checks++; if (dly_o !== 5'd1) begin n_fail++; $display("FAIL d1_dly_o got %0d exp 1", dly_o); end
   endtask

   task automatic test_stream_d5();
      drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 5'd5);
      n_checks++; if (dly_o !== 5'd5 || dly_err !== 1'b0) begin n_fail++; $display("FAIL d5_load got %0d/%b exp 5/0", dly_o, dly_err); end
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, DW'(i), 1'b1, 1'b0, 1'b0, 5'd0);
         n_checks++; if (vo !== (i >= 4)) begin n_fail++; $display("FAIL d5_vo[%0d] got %b exp %b", i, vo, (i >= 4)); end
         if (i >= 4) begin
            n_checks++; if (xo !== DW'(i - 4)) begin n_fail++; $display("FAIL d5_xo[%0d] got %h exp %h", i, xo, DW'(i - 4)); end
         end
`ifdef DELAY_LINE_OCC_EN
         n_checks++; if (occ !== DLW'((i + 1 > 5) ? 5 : i + 1)) begin n_fail++; $display("FAIL d5_occ[%0d] got %0d", i, occ); end
`endif
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 12; i++) begin
         drive((i < 4 || i > 6), DW'($urandom), 1'b1, 1'b0, 1'b0, 5'd0);
         n_checks++; if (xo !== exp_xo() || vo !== exp_vo()) begin n_fail++; $display("FAIL stall[%0d] got %h/%b exp %h/%b", i, xo, vo, exp_xo(), exp_vo()); end
`ifdef DELAY_LINE_OCC_EN
         n_checks++; if (occ !== exp_occ()) begin n_fail++; $display("FAIL stall_occ[%0d] got %0d exp %0d", i, occ, exp_occ()); end
`endif
      end
   endtask

   task automatic test_clamp();
      logic [DLW-1:0] req [6] = '{5'd0, 5'd20, 5'd7, 5'd31, 5'd16, 5'd1};
      logic [DLW-1:0] dex [6] = '{5'd1, 5'd16, 5'd7, 5'd16, 5'd16, 5'd1};
      logic           eex [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, req[i]);
         n_checks++; if (dly_o !== dex[i] || dly_err !== eex[i]) begin n_fail++; $display("FAIL clamp[%0d] got %0d/%b exp %0d/%b", i, dly_o, dly_err, dex[i], eex[i]); end
         drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd9);
         n_checks++; if (dly_o !== dex[i] || dly_err !== 1'b0) begin n_fail++; $display("FAIL clamp_hold[%0d] got %0d/%b exp %0d/0", i, dly_o, dly_err, dex[i]); end
      end
   endtask

   task automatic test_flush();
      drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 5'd4);
      for (int i = 0; i < 6; i++) drive(1'b1, DW'(8'h10 + i), 1'b1, 1'b0, 1'b0, 5'd0);
      drive(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 5'd0);
      n_checks++; if (vo !== 1'b0) begin n_fail++; $display("FAIL flush_vo got %b exp 0", vo); end
`ifdef DELAY_LINE_OCC_EN
      n_checks++; if (occ !== 5'd0) begin n_fail++; $display("FAIL flush_occ got %0d exp 0", occ); end
`endif
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, DW'(8'h30 + i), 1'b1, 1'b0, 1'b0, 5'd0);
         n_checks++; if (vo !== (i >= 3)) begin n_fail++; $display("FAIL flush_vo[%0d] got %b exp %b", i, vo, (i >= 3)); end
         n_checks++; if (xo !== exp_xo()) begin n_fail++; $display("FAIL flush_xo[%0d] got %h exp %h", i, xo, exp_xo()); end
      end
      drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 5'd6);
      n_checks++; if (dly_o !== 5'd6 || vo !== 1'b0) begin n_fail++; $display("FAIL ld_flush got %0d/%b exp 6/0", dly_o, vo); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, DW'($urandom), 1'($urandom), $urandom_range(0, 19) == 0,
               $urandom_range(0, 24) == 0, DLW'($urandom));
         n_checks++;
         if (xo !== exp_xo() || vo !== exp_vo() || dly_o !== DLW'(m_dly) || dly_err !== m_err) begin
            n_fail++;
            $display("FAIL rand[%0d] got %h/%b/%0d/%b exp %h/%b/%0d/%b", i, xo, vo, dly_o, dly_err,
                     exp_xo(), exp_vo(), m_dly, m_err);
         end
`ifdef DELAY_LINE_OCC_EN
         n_checks++; if (occ !== exp_occ()) begin n_fail++; $display("FAIL rand_occ[%0d] got %0d exp %0d", i, occ, exp_occ()); end
`endif
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 5'd8);
      for (int i = 0; i < 10; i++) drive(1'b1, DW'(8'hC0 + i), 1'b1, 1'b0, 1'b0, 5'd0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++; if (xo !== 8'h00 || vo !== 1'b0) begin n_fail++; $display("FAIL arst_out got %h/%b exp 00/0", xo, vo); end
      n_checks++; if (dly_o !== DLW'(DLT_INIT) || dly_err !== 1'b0) begin n_fail++; $display("FAIL arst_dly got %0d/%b exp %0d/0", dly_o, dly_err, DLT_INIT); end
`ifdef DELAY_LINE_OCC_EN
      n_checks++; if (occ !== 5'd0) begin n_fail++; $display("FAIL arst_occ got %0d exp 0", occ); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, DW'(8'hE0 + i), 1'b1, 1'b0, 1'b0, 5'd0);
         n_checks++; if (xo !== DW'(8'hE0 + i) || vo !== 1'b1) begin n_fail++; $display("FAIL arst_d1[%0d] got %h/%b exp %h/1", i, xo, vo, DW'(8'hE0 + i)); end
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_stream_d5();
      test_stall();
      test_clamp();
      test_flush();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
